obj_renderer: RTL and testbench

// Parametrised sprite renderer; generalises the fixed 4-object bitmap table into a run-time engine.
// Per frame: holds position / enable / mirror state for NUM_OBJ objects, double-buffered.
// Per pixel from the video timing chain: tests every object, looks up its bitmap bit and

---
 rtl/obj_renderer.sv | 186 ++++++++++++++++++
 tb/tb_obj_renderer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/obj_renderer.sv
// Sprite renderer: double-buffered per-object position/enable/mirror state, a two-stage
// per-pixel hit pipeline with priority resolve, and per-frame collision snapshots.
module obj_renderer #(
    parameter int NUM_OBJ    = 4,
    parameter int MAX_SIZE_X = 16,
    parameter int MAX_SIZE_Y = 64,
    parameter int COORD_W    = 11,
    localparam int SXW  = $clog2(MAX_SIZE_X + 1),
    localparam int SYW  = $clog2(MAX_SIZE_Y + 1),
    localparam int IDW  = $clog2(NUM_OBJ),
    localparam int UIDW = IDW + 1,
    localparam int COLW = $clog2(MAX_SIZE_X),
    localparam int ROWW = $clog2(MAX_SIZE_Y)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_OBJ*MAX_SIZE_Y*MAX_SIZE_X-1:0] bitmap,
    input  logic [NUM_OBJ*SXW-1:0]                size_x,
    input  logic [NUM_OBJ*SYW-1:0]                size_y,
    input  logic                                  frame_start,
    input  logic                                  upd_valid,
    output logic                                  upd_ready,
    input  logic [UIDW-1:0]                       upd_id,
    input  logic [COORD_W-1:0]                    upd_x,
    input  logic [COORD_W-1:0]                    upd_y,
    input  logic                                  upd_en,
    input  logic                                  upd_flip,
    input  logic                                  pix_valid,
    input  logic [COORD_W-1:0]                    pix_x,
    input  logic [COORD_W-1:0]                    pix_y,
    output logic                                  out_valid,
    output logic [NUM_OBJ-1:0]                    hit,
    output logic                                  pix_on,
    output logic [IDW-1:0]                        obj_id,
    output logic [NUM_OBJ-1:0]                    coll_flags
);

    logic [MAX_SIZE_X-1:0] rows [NUM_OBJ][MAX_SIZE_Y];
    logic [SXW-1:0]        sx   [NUM_OBJ];
    logic [SYW-1:0]        sy   [NUM_OBJ];

    logic [COORD_W-1:0] sh_x  [NUM_OBJ];
    logic [COORD_W-1:0] sh_y  [NUM_OBJ];
    logic [NUM_OBJ-1:0] sh_en;
    logic [NUM_OBJ-1:0] sh_flip;
    logic [COORD_W-1:0] act_x [NUM_OBJ];
    logic [COORD_W-1:0] act_y [NUM_OBJ];
    logic [NUM_OBJ-1:0] act_en;
    logic [NUM_OBJ-1:0] act_flip;

    logic [COORD_W:0]   dx_full [NUM_OBJ];
    logic [COORD_W:0]   dy_full [NUM_OBJ];
    logic [NUM_OBJ-1:0] in_box_c;

    logic               s1_valid;
    logic [NUM_OBJ-1:0] s1_in;
    logic [NUM_OBJ-1:0] s1_flip;
    logic [COLW-1:0]    s1_dx [NUM_OBJ];
    logic [ROWW-1:0]    s1_dy [NUM_OBJ];

    logic [ROWW-1:0]    row_idx [NUM_OBJ];
    logic [COLW-1:0]    col_idx [NUM_OBJ];
    logic [COLW-1:0]    bit_idx [NUM_OBJ];
    logic [NUM_OBJ-1:0] bit_c;
    logic [NUM_OBJ-1:0] hit_c;
    logic [IDW-1:0]     id_c;

    logic [NUM_OBJ-1:0] acc;
    logic [NUM_OBJ-1:0] coll_term;
    logic               multi;

    logic upd_fire;

    // Per-object row/index arithmetic; sizes are bounded by the bitmap so only the low
    // ROWW/COLW bits matter and modular wrap in those widths gives the right index.
    for (genvar gi = 0; gi < NUM_OBJ; gi++) begin : g_obj
        assign sx[gi] = size_x[gi*SXW +: SXW];
        assign sy[gi] = size_y[gi*SYW +: SYW];
        for (genvar gr = 0; gr < MAX_SIZE_Y; gr++) begin : g_row
            assign rows[gi][gr] = bitmap[(gi*MAX_SIZE_Y + gr)*MAX_SIZE_X +: MAX_SIZE_X];
        end

        assign dx_full[gi]  = {1'b0, pix_x} - {1'b0, act_x[gi]};
        assign dy_full[gi]  = {1'b0, pix_y} - {1'b0, act_y[gi]};
        assign in_box_c[gi] = act_en[gi] & ~dx_full[gi][COORD_W] & ~dy_full[gi][COORD_W]
                            & (dx_full[gi][COORD_W-1:0] < COORD_W'(sx[gi]))
                            & (dy_full[gi][COORD_W-1:0] < COORD_W'(sy[gi]));

        assign row_idx[gi] = ROWW'(sy[gi]) - ROWW'(1) - s1_dy[gi];
        assign col_idx[gi] = s1_flip[gi] ? (COLW'(sx[gi]) - COLW'(1) - s1_dx[gi]) : s1_dx[gi];
        assign bit_idx[gi] = COLW'(sx[gi]) - COLW'(1) - col_idx[gi];
        assign bit_c[gi]   = s1_in[gi] & rows[gi][row_idx[gi]][bit_idx[gi]];
    end

    assign upd_fire = upd_valid & upd_ready & (upd_id < UIDW'(NUM_OBJ));

    // Shadow takes host writes; active is loaded from the pre-edge shadow on frame_start,
    // so a write landing on the frame_start cycle waits for the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_ready <= 1'b0;
            sh_en     <= '0;
            sh_flip   <= '0;
            act_en    <= '0;
            act_flip  <= '0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                sh_x[i]  <= '0;
                sh_y[i]  <= '0;
                act_x[i] <= '0;
                act_y[i] <= '0;
            end
        end else begin
            upd_ready <= ~frame_start;
            if (frame_start) begin
                act_en   <= sh_en;
                act_flip <= sh_flip;
                for (int i = 0; i < NUM_OBJ; i++) begin
                    act_x[i] <= sh_x[i];
                    act_y[i] <= sh_y[i];
                end
            end
            if (upd_fire) begin
                sh_x[upd_id[IDW-1:0]]    <= upd_x;
                sh_y[upd_id[IDW-1:0]]    <= upd_y;
                sh_en[upd_id[IDW-1:0]]   <= upd_en;
                sh_flip[upd_id[IDW-1:0]] <= upd_flip;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_in    <= '0;
            s1_flip  <= '0;
            for (int i = 0; i < NUM_OBJ; i++) begin
                s1_dx[i] <= '0;
                s1_dy[i] <= '0;
            end
        end else begin
            s1_valid <= pix_valid;
            s1_in    <= in_box_c;
            s1_flip  <= act_flip;
            for (int i = 0; i < NUM_OBJ; i++) begin
                s1_dx[i] <= dx_full[i][COLW-1:0];
                s1_dy[i] <= dy_full[i][ROWW-1:0];
            end
        end
    end

    assign hit_c = s1_valid ? bit_c : '0;

    // Lowest index wins priority.
    always_comb begin
        id_c = '0;
        for (int i = NUM_OBJ - 1; i >= 0; i--) begin
            if (hit_c[i]) id_c = IDW'(i);
        end
    end

    assign multi     = |(hit & (hit - NUM_OBJ'(1)));
    assign coll_term = hit & {NUM_OBJ{multi}};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            hit        <= '0;
            pix_on     <= 1'b0;
            obj_id     <= '0;
            acc        <= '0;
            coll_flags <= '0;
        end else begin
            out_valid <= s1_valid;
            hit       <= hit_c;
            pix_on    <= |hit_c;
            obj_id    <= id_c;
            if (frame_start) begin
                coll_flags <= acc | coll_term;
                acc        <= '0;
            end else begin
                acc <= acc | coll_term;
            end
        end
    end

endmodule

// File: tb/tb_obj_renderer.sv
// Randomised bench for obj_renderer against a plain-arithmetic sprite model, with
// directed cases for flip, commit timing, collisions and mid-frame reset.
module tb_obj_renderer;

    logic            clk = 1'b0;
    logic            rst;
    logic [4095:0]   bitmap;
    logic [19:0]     size_x;
    logic [27:0]     size_y;
    logic            frame_start, upd_valid, upd_ready;
    logic [2:0]      upd_id;
    logic [10:0]     upd_x, upd_y, pix_x, pix_y;
    logic            upd_en, upd_flip, pix_valid;
    logic            out_valid, pix_on;
    logic [3:0]      hit, coll_flags;
    logic [1:0]      obj_id;

    int checks = 0;
    int errors = 0;

    logic [15:0] bm [4][64];
    int SX [4] = '{16, 8, 16, 5};
    int SY [4] = '{64, 8, 64, 10};

    int mx [4], my [4], ax [4], ay [4];
    logic [3:0] men, mflip, aen, aflip;
    logic [3:0] macc, mcoll;
    logic       pendV;
    logic [3:0] pendHit;

    obj_renderer dut (
        .clk(clk), .rst(rst), .bitmap(bitmap), .size_x(size_x), .size_y(size_y),
        .frame_start(frame_start), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_id(upd_id), .upd_x(upd_x), .upd_y(upd_y), .upd_en(upd_en), .upd_flip(upd_flip),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .out_valid(out_valid),
        .hit(hit), .pix_on(pix_on), .obj_id(obj_id), .coll_flags(coll_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] modelHit(int px, int py);
        logic [3:0] h = '0;
        for (int i = 0; i < 4; i++) begin
            if (aen[i] && px >= ax[i] && py >= ay[i] && px - ax[i] < SX[i] && py - ay[i] < SY[i]) begin
                int dx = px - ax[i];
                int dy = py - ay[i];
                int b = aflip[i] ? dx : SX[i] - 1 - dx;
                h[i] = bm[i][SY[i] - 1 - dy][b];
            end
        end
        return h;
    endfunction

    function automatic logic [1:0] lowId(logic [3:0] h);
        logic [1:0] r = '0;
        for (int i = 3; i >= 0; i--) if (h[i]) r = 2'(i);
        return r;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) begin
            mx[i] = 0; my[i] = 0; ax[i] = 0; ay[i] = 0;
        end
        men = '0; mflip = '0; aen = '0; aflip = '0;
        macc = '0; mcoll = '0; pendV = 1'b0; pendHit = '0;
    endtask

    task automatic step(input logic v, input int px, input int py);
        logic [3:0] e;
        pix_valid = v;
        pix_x = 11'(px);
        pix_y = 11'(py);
        e = v ? modelHit(px, py) : 4'b0;
        tick();
        checkOutput("out_valid", 32'(out_valid), 32'(pendV));
        checkOutput("hit", 32'(hit), 32'(pendHit));
        checkOutput("pix_on", 32'(pix_on), 32'(|pendHit));
        checkOutput("obj_id", 32'(obj_id), 32'(lowId(pendHit)));
        if ($countones(pendHit) >= 2) macc = macc | pendHit;
        pendV = v;
        pendHit = e;
    endtask

    task automatic pixelOnce(input int px, input int py);
        step(1'b1, px, py);
        step(1'b0, 0, 0);
    endtask

    task automatic applyStimulus(input int n, input bit edgeRegion);
        for (int k = 0; k < n; k++) begin
            int px, py;
            if (edgeRegion) begin
                px = $urandom_range(0, 33);
                py = $urandom_range(0, 33);
                px = (px < 18) ? 2030 + px : px - 18;
                py = (py < 18) ? 2030 + py : py - 18;
            end else begin
                px = $urandom_range(0, 120);
                py = $urandom_range(0, 120);
            end
            step($urandom_range(0, 3) != 0, px, py);
        end
        step(1'b0, 0, 0);
    endtask

    task automatic doUpdate(input int id, input int x, input int y, input logic en, input logic fl);
        checkOutput("upd_ready_pre", 32'(upd_ready), 32'd1);
        upd_valid = 1'b1; upd_id = 3'(id); upd_x = 11'(x); upd_y = 11'(y);
        upd_en = en; upd_flip = fl;
        tick();
        upd_valid = 1'b0;
        if (id < 4) begin
            mx[id] = x; my[id] = y; men[id] = en; mflip[id] = fl;
        end
    endtask

    task automatic doFrame(input logic wr, input int id, input int x, input int y, input logic en, input logic fl);
        frame_start = 1'b1;
        upd_valid = wr; upd_id = 3'(id); upd_x = 11'(x); upd_y = 11'(y);
        upd_en = en; upd_flip = fl;
        tick();
        frame_start = 1'b0;
        upd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ax[i] = mx[i]; ay[i] = my[i];
        end
        aen = men; aflip = mflip;
        if (wr && id < 4) begin
            mx[id] = x; my[id] = y; men[id] = en; mflip[id] = fl;
        end
        mcoll = macc;
        macc = '0;
        checkOutput("upd_ready_after_frame", 32'(upd_ready), 32'd0);
        checkOutput("coll_flags", 32'(coll_flags), 32'(mcoll));
        tick();
        checkOutput("upd_ready_recover", 32'(upd_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++)
            for (int r = 0; r < 64; r++)
                bm[i][r] = 16'($urandom);
        bm[0][8] = 16'b1111111001111111;
        for (int r = 0; r < 8; r++) bm[1][r] = 16'hFFFF;
        bm[2][63][0] = 1'b1;
        bm[2][63][15] = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int r = 0; r < 64; r++)
                bitmap[(i*64 + r)*16 +: 16] = bm[i][r];
        size_x = {5'd5, 5'd16, 5'd8, 5'd16};
        size_y = {7'd10, 7'd64, 7'd8, 7'd64};

        rst = 1'b1; frame_start = 1'b0; upd_valid = 1'b0; upd_id = '0;
        upd_x = '0; upd_y = '0; upd_en = 1'b0; upd_flip = 1'b0;
        pix_valid = 1'b0; pix_x = '0; pix_y = '0;
        modelReset();
        #23;
        checkOutput("rst_upd_ready", 32'(upd_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_hit", 32'(hit), 32'd0);
        checkOutput("rst_coll", 32'(coll_flags), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("ready_after_rst", 32'(upd_ready), 32'd1);

        $display("[TB] directed: basic hit and hole");
        doUpdate(0, 100, 50, 1'b1, 1'b0);
        doFrame(1'b0, 0, 0, 0, 1'b0, 1'b0);
        pixelOnce(105, 105);
        checkOutput("t1_hit_const", 32'(hit), 32'h1);
        checkOutput("t1_id_const", 32'(obj_id), 32'h0);
        pixelOnce(107, 105);
        checkOutput("t2_hole_const", 32'(hit), 32'h0);

        $display("[TB] directed: mirror");
        doUpdate(2, 0, 0, 1'b1, 1'b1);
        doFrame(1'b0, 0, 0, 0, 1'b0, 1'b0);
        pixelOnce(0, 0);
        checkOutput("t3_flip_const", 32'(hit), 32'h4);
        doUpdate(2, 0, 0, 1'b1, 1'b0);
        doFrame(1'b0, 0, 0, 0, 1'b0, 1'b0);
        pixelOnce(0, 0);
        checkOutput("t3_noflip_const", 32'(hit), 32'h0);

        $display("[TB] directed: write on frame_start cycle");
        doUpdate(1, 200, 200, 1'b1, 1'b0);
        doFrame(1'b0, 0, 0, 0, 1'b0, 1'b0);
        doFrame(1'b1, 1, 300, 300, 1'b1, 1'b0);
        pixelOnce(200, 200);
        checkOutput("t4_old_pos_const", 32'(hit), 32'h2);
        pixelOnce(300, 300);
        checkOutput("t4_new_pos_early", 32'(hit), 32'h0);
        doFrame(1'b0, 0, 0, 0, 1'b0, 1'b0);
        pixelOnce(300, 300);
        checkOutput("t4_new_pos_const", 32'(hit), 32'h2);

        $display("[TB] directed: collisions");
        doUpdate(1, 100, 100, 1'b1, 1'b0);
        doFrame(1'b0, 0, 0, 0, 1'b0, 1'b0);
        pixelOnce(105, 105);
        checkOutput("t5_overlap_const", 32'(hit), 32'h3);
        doFrame(1'b0, 0, 0, 0, 1'b0, 1'b0);
        checkOutput("t5_coll_const", 32'(coll_flags), 32'h3);
        pixelOnce(107, 105);
        doFrame(1'b0, 0, 0, 0, 1'b0, 1'b0);
        checkOutput("t5_nocoll_const", 32'(coll_flags), 32'h0);
        pixelOnce(105, 105);
        doFrame(1'b0, 0, 0, 0, 1'b0, 1'b0);

        $display("[TB] directed: mid-frame reset");
        step(1'b1, 105, 105);
        step(1'b1, 105, 105);
        rst = 1'b1;
        #1;
        checkOutput("t6_hit", 32'(hit), 32'd0);
        checkOutput("t6_pix_on", 32'(pix_on), 32'd0);
        checkOutput("t6_out_valid", 32'(out_valid), 32'd0);
        checkOutput("t6_obj_id", 32'(obj_id), 32'd0);
        checkOutput("t6_coll", 32'(coll_flags), 32'd0);
        checkOutput("t6_ready", 32'(upd_ready), 32'd0);
        rst = 1'b0;
        modelReset();
        pix_valid = 1'b0;
        tick();
        checkOutput("t6_ready_release", 32'(upd_ready), 32'd1);
        step(1'b0, 0, 0);
        doUpdate(0, 100, 50, 1'b1, 1'b0);
        doFrame(1'b0, 0, 0, 0, 1'b0, 1'b0);
        doUpdate(7, 0, 0, 1'b1, 1'b1);
        doFrame(1'b0, 0, 0, 0, 1'b0, 1'b0);
        pixelOnce(0, 0);
        checkOutput("t6_id7_dropped", 32'(hit), 32'h0);
        pixelOnce(105, 105);
        checkOutput("t6_obj0_kept", 32'(hit), 32'h1);

        $display("[TB] random frames");
        for (int f = 0; f < 8; f++) begin
            for (int k = 0; k < 4; k++)
                doUpdate($urandom_range(0, 7), $urandom_range(0, 90), $urandom_range(0, 90),
                         $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
            doFrame(1'b0, 0, 0, 0, 1'b0, 1'b0);
            applyStimulus(150, 1'b0);
            doFrame(1'b0, 0, 0, 0, 1'b0, 1'b0);
        end

        $display("[TB] coordinate edge");
        doUpdate(3, 2044, 2040, 1'b1, 1'b0);
        doUpdate(2, 2040, 2035, 1'b1, 1'b1);
        doUpdate(0, 2047, 2047, 1'b1, 1'b0);
        doFrame(1'b0, 0, 0, 0, 1'b0, 1'b0);
        applyStimulus(300, 1'b1);
        doFrame(1'b0, 0, 0, 0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
